ucsbece154b_branch_resolve: RTL and testbench
=============================================

UCSBECE154B_BRANCH_RESOLVE -- requirements
Module: ucsbece154b_branch_resolve

Interface
REQ-001 SHALL have parameter NUM_GHR_BITS, default 6, giving the width of the GHR snapshot carried F->E.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock.
- reset_ni  in  1  asynchronous, active-low reset.
- StallD_i  in  1  hold the F->D prediction register.
- FlushD_i  in  1  invalidate the F->D prediction register.
- FlushE_i  in  1  invalidate the D->E prediction register.
- PredTakenF_i  in  1  predictor BranchTaken in F.
- PredTargetF_i  in  32  predictor BTB target in F.
- GHRF_i  in  NUM_GHR_BITS  GHR value used for the F prediction.
- opE_i  in  7  opcode of the E-stage instruction.
- BranchCondE_i  in  1  ALU branch-condition-true in E.
- PCTargetE_i  in  32  computed target in E.
- PCPlus4E_i  in  32  fall-through PC in E.
- MispredictE_o  out  1  E-stage misprediction.
- RedirectPCE_o  out  32  correct next PC on a misprediction.
- PHTincrementE_o  out  1  resolved branch taken.
- BTBweE_o  out  1  BTB/PHT update enable.
- GHRrestoreE_o  out  1  overwrite the predictor GHR.
- GHRrestoreValE_o  out  NUM_GHR_BITS  restored GHR value.

Function
REQ-003 The F->D register {valid, taken, target, ghr} SHALL load {1, PredTakenF_i, PredTargetF_i, GHRF_i} each cycle; FlushD_i clears valid; otherwise StallD_i holds it; flush beats stall.
REQ-004 The D->E register SHALL load the F->D contents each cycle; FlushE_i clears valid; there is no E stall.
REQ-005 Decode in E: isB = (opE_i==99), isJ = (opE_i==111 or opE_i==103), ctrl = isB|isJ.
REQ-006 actual = (isB & BranchCondE_i) | isJ.
REQ-007 MispredictE_o SHALL equal valid_e & (ctrl ? (actual != taken_e) | (actual & taken_e & target_e != PCTargetE_i) : taken_e).
- A non-control instruction predicted taken (BTB alias) is a mispredict that redirects to PCPlus4E_i.
REQ-008 RedirectPCE_o SHALL be actual ? PCTargetE_i : PCPlus4E_i, valid in every cycle and used only when MispredictE_o=1.
REQ-009 PHTincrementE_o = valid_e & isB & BranchCondE_i; BTBweE_o = valid_e & ctrl.
REQ-010 GHRrestoreE_o = MispredictE_o; GHRrestoreValE_o = isB ? {actual, ghr_e[NUM_GHR_BITS-1:1]} : ghr_e.
REQ-011 All E outputs SHALL be combinational from the D->E register and E inputs (zero added latency).
REQ-012 A flush asserted in the same cycle as a mispredict SHALL NOT change that cycle's outputs; it takes effect on the next edge.
REQ-013 The hazard unit drives FlushD_i/FlushE_i on MispredictE_o; this block SHALL NOT self-flush.

Reset
REQ-014 reset_ni=0 SHALL asynchronously clear both valid bits and zero all stored taken/target/ghr fields.
REQ-015 During reset, all outputs SHALL be 0, except RedirectPCE_o, which follows REQ-008.
REQ-016 Reset asserted mid-operation discards in-flight predictions; the first E result after release requires two loads.

Configuration
REQ-017 Macro BRANCH_RESOLVE_STATS_EN: when defined, adds outputs BranchCountE_o[31:0] and MispredCountE_o[31:0].
- BranchCountE_o increments on each cycle with valid_e & ctrl.
- MispredCountE_o increments on each cycle with MispredictE_o.
- Both saturate at 0xFFFFFFFF and reset to 0.
- When undefined, these ports and counters SHALL be absent.

Structure
REQ-018 Opcode constants (OP_BRANCH=99, OP_JAL=111, OP_JALR=103) SHALL live in shared ucsbece154b_defines.vh.
REQ-019 One sub-module, ucsbece154b_predpipe, SHALL implement one {valid, taken, target, ghr} stage with flush/stall, instantiated twice.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- BEQ with pred taken, target 0x100; E: BranchCondE_i=1, PCTargetE_i=0x100 -> MispredictE_o=0, PHTincrementE_o=1, BTBweE_o=1.
- BEQ with pred not-taken, GHRF_i=6'b000101; E: cond=1, PCTargetE_i=0x200 -> MispredictE_o=1, RedirectPCE_o=0x200, GHRrestoreValE_o=6'b100010.
- JALR with pred taken, target 0x300; PCTargetE_i=0x304 -> MispredictE_o=1, RedirectPCE_o=0x304.
- ADD (op 51) with pred taken, PCPlus4E_i=0x48 -> MispredictE_o=1, RedirectPCE_o=0x48, BTBweE_o=0.
- Pred taken with StallD_i=1 and FlushD_i=1 in the same cycle -> valid cleared; two cycles later MispredictE_o=0 and BTBweE_o=0.
- With BRANCH_RESOLVE_STATS_EN: 3 branches, 1 mispredict, then reset_ni pulse -> counts 3/1, then 0/0 asynchronously.

Source files
------------

// File: rtl/ucsbece154b_branch_resolve_pkg.sv
// Package for the branch-resolve slice: opcode constants and the
// control-flow decode helper used in the E stage.
package ucsbece154b_branch_resolve_pkg;

`include "ucsbece154b_defines.vh"

  localparam logic [6:0] OP_BRANCH = `OP_BRANCH;
  localparam logic [6:0] OP_JAL    = `OP_JAL;
  localparam logic [6:0] OP_JALR   = `OP_JALR;

  // Kind of control-flow instruction sitting in E.
  typedef enum logic [1:0] {
    CF_NONE   = 2'd0,
    CF_BRANCH = 2'd1,
    CF_JUMP   = 2'd2
  } cf_kind_e;

  // Conditional branches resolve on the ALU condition; jumps always redirect.
  function automatic cf_kind_e decode_cf(input logic [6:0] op);
    cf_kind_e kind;
    kind = CF_NONE;
    if (op == OP_BRANCH) begin
      kind = CF_BRANCH;
    end else if ((op == OP_JAL) || (op == OP_JALR)) begin
      kind = CF_JUMP;
    end
    return kind;
  endfunction

endpackage

// File: rtl/ucsbece154b_defines.vh
// Shared opcode constants for the ucsbece154b pipeline.
// Guarded so that several files may include it in one compilation.
`ifndef UCSBECE154B_DEFINES_VH
`define UCSBECE154B_DEFINES_VH

`define OP_BRANCH 7'd99
`define OP_JAL    7'd111
`define OP_JALR   7'd103

`endif

// File: rtl/ucsbece154b_predpipe.sv
// One pipeline stage of the predictor metadata {valid, taken, target, ghr}.
// A flush clears valid and wins over a stall; a stall holds every field.
module ucsbece154b_predpipe #(
  parameter int NUM_GHR_BITS = 6
) (
  input  logic                    clk,
  input  logic                    reset_ni,
  input  logic                    stall_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  input  logic                    taken_i,
  input  logic [31:0]             target_i,
  input  logic [NUM_GHR_BITS-1:0] ghr_i,
  output logic                    valid_o,
  output logic                    taken_o,
  output logic [31:0]             target_o,
  output logic [NUM_GHR_BITS-1:0] ghr_o
);

  logic                    valid_q;
  logic                    taken_q;
  logic [31:0]             target_q;
  logic [NUM_GHR_BITS-1:0] ghr_q;

  // Stage register: reset clears everything, flush drops valid, stall holds.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_q  <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
      ghr_q    <= '0;
    end else if (flush_i) begin
      valid_q  <= 1'b0;
      taken_q  <= taken_i;
      target_q <= target_i;
      ghr_q    <= ghr_i;
    end else if (!stall_i) begin
      valid_q  <= valid_i;
      taken_q  <= taken_i;
      target_q <= target_i;
      ghr_q    <= ghr_i;
    end
  end

  assign valid_o  = valid_q;
  assign taken_o  = taken_q;
  assign target_o = target_q;
  assign ghr_o    = ghr_q;

endmodule

// File: rtl/ucsbece154b_branch_resolve.sv
// Branch resolution in E: carries the F-stage prediction through D and E,
// compares it with the resolved outcome and produces redirect / predictor
// update signals. All E outputs are combinational from the D->E register.
// Optional macro BRANCH_RESOLVE_STATS_EN adds saturating branch and
// mispredict counters.
// Flow: the F-stage prediction enters the F->D stage every cycle as valid;
// the hazard unit flushes on MispredictE_o, this block never flushes itself.
module ucsbece154b_branch_resolve
  import ucsbece154b_branch_resolve_pkg::*;
#(
  parameter int NUM_GHR_BITS = 6
) (
  input  logic                    clk,
  input  logic                    reset_ni,
  input  logic                    StallD_i,
  input  logic                    FlushD_i,
  input  logic                    FlushE_i,
  input  logic                    PredTakenF_i,
  input  logic [31:0]             PredTargetF_i,
  input  logic [NUM_GHR_BITS-1:0] GHRF_i,
  input  logic [6:0]              opE_i,
  input  logic                    BranchCondE_i,
  input  logic [31:0]             PCTargetE_i,
  input  logic [31:0]             PCPlus4E_i,
  output logic                    MispredictE_o,
  output logic [31:0]             RedirectPCE_o,
  output logic                    PHTincrementE_o,
  output logic                    BTBweE_o,
  output logic                    GHRrestoreE_o,
`ifdef BRANCH_RESOLVE_STATS_EN
  output logic [31:0]             BranchCountE_o,
  output logic [31:0]             MispredCountE_o,
`endif
  output logic [NUM_GHR_BITS-1:0] GHRrestoreValE_o
);

  // F->D stage outputs
  logic                    valid_d;
  logic                    taken_d;
  logic [31:0]             target_d;
  logic [NUM_GHR_BITS-1:0] ghr_d;

  // D->E stage outputs
  logic                    valid_e;
  logic                    taken_e;
  logic [31:0]             target_e;
  logic [NUM_GHR_BITS-1:0] ghr_e;

  ucsbece154b_predpipe #(.NUM_GHR_BITS(NUM_GHR_BITS)) u_pipe_fd (
    .clk      (clk),
    .reset_ni (reset_ni),
    .stall_i  (StallD_i),
    .flush_i  (FlushD_i),
    .valid_i  (1'b1),
    .taken_i  (PredTakenF_i),
    .target_i (PredTargetF_i),
    .ghr_i    (GHRF_i),
    .valid_o  (valid_d),
    .taken_o  (taken_d),
    .target_o (target_d),
    .ghr_o    (ghr_d)
  );

  // E never stalls; only a flush can drop the entry.
  ucsbece154b_predpipe #(.NUM_GHR_BITS(NUM_GHR_BITS)) u_pipe_de (
    .clk      (clk),
    .reset_ni (reset_ni),
    .stall_i  (1'b0),
    .flush_i  (FlushE_i),
    .valid_i  (valid_d),
    .taken_i  (taken_d),
    .target_i (target_d),
    .ghr_i    (ghr_d),
    .valid_o  (valid_e),
    .taken_o  (taken_e),
    .target_o (target_e),
    .ghr_o    (ghr_e)
  );

  cf_kind_e cf_kind;
  logic     is_b;
  logic     is_j;
  logic     ctrl;
  logic     actual;
  logic     mispredict;

  // Decode the E instruction and compute the resolved direction.
  always_comb begin
    cf_kind = decode_cf(opE_i);
    is_b    = (cf_kind == CF_BRANCH);
    is_j    = (cf_kind == CF_JUMP);
    ctrl    = is_b | is_j;
    actual  = (is_b & BranchCondE_i) | is_j;
  end

  // Compare prediction with outcome; a non-control instruction predicted
  // taken is a BTB alias and must fall through.
  always_comb begin
    mispredict = 1'b0;
    if (valid_e) begin
      if (ctrl) begin
        mispredict = (actual != taken_e) ||
                     (actual && taken_e && (target_e != PCTargetE_i));
      end else begin
        mispredict = taken_e;
      end
    end
  end

  // Drive the E outputs; the GHR value is only meaningful for a valid entry,
  // so it is forced to zero otherwise (which also keeps it 0 during reset).
  always_comb begin
    MispredictE_o    = mispredict;
    RedirectPCE_o    = actual ? PCTargetE_i : PCPlus4E_i;
    PHTincrementE_o  = valid_e & is_b & BranchCondE_i;
    BTBweE_o         = valid_e & ctrl;
    GHRrestoreE_o    = mispredict;
    GHRrestoreValE_o = '0;
    if (valid_e) begin
      GHRrestoreValE_o = is_b ? {actual, ghr_e[NUM_GHR_BITS-1:1]} : ghr_e;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] branch_cnt_d;
  logic [31:0] mispred_cnt_q;
  logic [31:0] mispred_cnt_d;

  // Saturating next-count for both statistics counters.
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (valid_e && ctrl && (branch_cnt_q != 32'hFFFF_FFFF)) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (mispredict && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // Counter registers, cleared asynchronously with the pipeline.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign BranchCountE_o  = branch_cnt_q;
  assign MispredCountE_o = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_ucsbece154b_branch_resolve.sv
// Directed bench for ucsbece154b_branch_resolve with hand-computed vectors.
module tb_ucsbece154b_branch_resolve;

  localparam int NG = 6;

  logic          clk;
  logic          reset_ni;
  logic          StallD_i;
  logic          FlushD_i;
  logic          FlushE_i;
  logic          PredTakenF_i;
  logic [31:0]   PredTargetF_i;
  logic [NG-1:0] GHRF_i;
  logic [6:0]    opE_i;
  logic          BranchCondE_i;
  logic [31:0]   PCTargetE_i;
  logic [31:0]   PCPlus4E_i;
  logic          MispredictE_o;
  logic [31:0]   RedirectPCE_o;
  logic          PHTincrementE_o;
  logic          BTBweE_o;
  logic          GHRrestoreE_o;
  logic [NG-1:0] GHRrestoreValE_o;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0]   BranchCountE_o;
  logic [31:0]   MispredCountE_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ucsbece154b_branch_resolve #(.NUM_GHR_BITS(NG)) dut (
    .clk              (clk),
    .reset_ni         (reset_ni),
    .StallD_i         (StallD_i),
    .FlushD_i         (FlushD_i),
    .FlushE_i         (FlushE_i),
    .PredTakenF_i     (PredTakenF_i),
    .PredTargetF_i    (PredTargetF_i),
    .GHRF_i           (GHRF_i),
    .opE_i            (opE_i),
    .BranchCondE_i    (BranchCondE_i),
    .PCTargetE_i      (PCTargetE_i),
    .PCPlus4E_i       (PCPlus4E_i),
    .MispredictE_o    (MispredictE_o),
    .RedirectPCE_o    (RedirectPCE_o),
    .PHTincrementE_o  (PHTincrementE_o),
    .BTBweE_o         (BTBweE_o),
    .GHRrestoreE_o    (GHRrestoreE_o),
`ifdef BRANCH_RESOLVE_STATS_EN
    .BranchCountE_o   (BranchCountE_o),
    .MispredCountE_o  (MispredCountE_o),
`endif
    .GHRrestoreValE_o (GHRrestoreValE_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_f(input logic taken, input logic [31:0] tgt, input logic [NG-1:0] ghr);
    PredTakenF_i  = taken;
    PredTargetF_i = tgt;
    GHRF_i        = ghr;
  endtask

  task automatic set_e(input logic [6:0] op, input logic cond, input logic [31:0] pct,
                       input logic [31:0] pc4);
    opE_i         = op;
    BranchCondE_i = cond;
    PCTargetE_i   = pct;
    PCPlus4E_i    = pc4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one prediction through F->D->E with a non-control E op meanwhile,
  // leaving an idle not-taken prediction behind it.
  task automatic load_pred(input logic taken, input logic [31:0] tgt, input logic [NG-1:0] ghr);
    set_f(taken, tgt, ghr);
    set_e(7'd0, 1'b0, 32'h0, 32'h0);
    tick();
    set_f(1'b0, 32'h0, '0);
    tick();
  endtask

  task automatic check_e(input string tag, input logic misp, input logic [31:0] redir,
                         input logic pht, input logic btbwe, input logic grest,
                         input logic [NG-1:0] gval);
    #1;
    check({tag, ".misp"},   32'(MispredictE_o),    32'(misp));
    check({tag, ".redir"},  RedirectPCE_o,         redir);
    check({tag, ".pht"},    32'(PHTincrementE_o),  32'(pht));
    check({tag, ".btbwe"},  32'(BTBweE_o),         32'(btbwe));
    check({tag, ".grest"},  32'(GHRrestoreE_o),    32'(grest));
    check({tag, ".gval"},   32'(GHRrestoreValE_o), 32'(gval));
  endtask

  initial begin
    reset_ni = 1'b0;
    StallD_i = 1'b0;
    FlushD_i = 1'b0;
    FlushE_i = 1'b0;
    set_f(1'b0, 32'h0, '0);
    set_e(7'd51, 1'b0, 32'h10, 32'h14);
    #12;

    // reset state: outputs 0, redirect follows the fall-through
    check_e("rst_add", 1'b0, 32'h14, 1'b0, 1'b0, 1'b0, 6'b000000);
    set_e(7'd99, 1'b1, 32'h20, 32'h24);
    check_e("rst_beq", 1'b0, 32'h20, 1'b0, 1'b0, 1'b0, 6'b000000);
    reset_ni = 1'b1;

    // BEQ predicted taken, correct target
    load_pred(1'b1, 32'h100, 6'b000000);
    set_e(7'd99, 1'b1, 32'h100, 32'h104);
    check_e("beq_tk_ok", 1'b0, 32'h100, 1'b1, 1'b1, 1'b0, 6'b100000);
    tick();

    // BEQ predicted not-taken, actually taken
    load_pred(1'b0, 32'h0, 6'b000101);
    set_e(7'd99, 1'b1, 32'h200, 32'h1C);
    check_e("beq_nt_bad", 1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 6'b100010);
    tick();

    // JALR predicted taken to a stale target
    load_pred(1'b1, 32'h300, 6'b110011);
    set_e(7'd103, 1'b0, 32'h304, 32'h58);
    check_e("jalr_tgt", 1'b1, 32'h304, 1'b0, 1'b1, 1'b1, 6'b110011);
    tick();

    // ADD predicted taken (BTB alias)
    load_pred(1'b1, 32'h40, 6'b001100);
    set_e(7'd51, 1'b0, 32'h80, 32'h48);
    check_e("add_alias", 1'b1, 32'h48, 1'b0, 1'b0, 1'b1, 6'b001100);
    tick();

    // BEQ predicted taken, actually not taken
    load_pred(1'b1, 32'h600, 6'b101101);
    set_e(7'd99, 1'b0, 32'h600, 32'h604);
    check_e("beq_tk_nt", 1'b1, 32'h604, 1'b0, 1'b1, 1'b1, 6'b010110);
    tick();

    // BEQ taken both ways but wrong target
    load_pred(1'b1, 32'h700, 6'b000000);
    set_e(7'd99, 1'b1, 32'h704, 32'h708);
    check_e("beq_tgt", 1'b1, 32'h704, 1'b1, 1'b1, 1'b1, 6'b100000);
    tick();

    // JAL predicted correctly
    load_pred(1'b1, 32'h800, 6'b010101);
    set_e(7'd111, 1'b0, 32'h800, 32'h10C);
    check_e("jal_ok", 1'b0, 32'h800, 1'b0, 1'b1, 1'b0, 6'b010101);
    tick();

    // stall and flush together on F->D: flush wins
    set_f(1'b1, 32'h900, '0);
    set_e(7'd0, 1'b0, 32'h0, 32'h0);
    StallD_i = 1'b1;
    FlushD_i = 1'b1;
    tick();
    StallD_i = 1'b0;
    FlushD_i = 1'b0;
    set_f(1'b0, 32'h0, '0);
    tick();
    set_e(7'd99, 1'b1, 32'h900, 32'h904);
    #1;
    check("stflush.misp",  32'(MispredictE_o),   32'd0);
    check("stflush.btbwe", 32'(BTBweE_o),        32'd0);
    check("stflush.pht",   32'(PHTincrementE_o), 32'd0);
    tick();

    // stall holds the F->D entry while F changes
    set_f(1'b1, 32'hA00, 6'b000011);
    set_e(7'd0, 1'b0, 32'h0, 32'h0);
    tick();
    StallD_i = 1'b1;
    set_f(1'b0, 32'h0, '0);
    tick();
    tick();
    StallD_i = 1'b0;
    set_e(7'd111, 1'b0, 32'hA00, 32'hA04);
    check_e("stall_hold", 1'b0, 32'hA00, 1'b0, 1'b1, 1'b0, 6'b000011);
    tick();

    // FlushE drops the D->E entry
    set_f(1'b1, 32'hB00, '0);
    set_e(7'd0, 1'b0, 32'h0, 32'h0);
    tick();
    set_f(1'b0, 32'h0, '0);
    FlushE_i = 1'b1;
    tick();
    FlushE_i = 1'b0;
    set_e(7'd51, 1'b0, 32'h0, 32'hB04);
    #1;
    check("flushe.misp",  32'(MispredictE_o), 32'd0);
    check("flushe.grest", 32'(GHRrestoreE_o), 32'd0);
    tick();

    // flush in the mispredict cycle only acts at the next edge
    load_pred(1'b1, 32'hC00, 6'b000000);
    set_e(7'd51, 1'b0, 32'h0, 32'hC04);
    FlushD_i = 1'b1;
    FlushE_i = 1'b1;
    #1;
    check("sameflush.misp",  32'(MispredictE_o), 32'd1);
    check("sameflush.redir", RedirectPCE_o,      32'hC04);
    check("sameflush.grest", 32'(GHRrestoreE_o), 32'd1);
    tick();
    FlushD_i = 1'b0;
    FlushE_i = 1'b0;
    check("sameflush.after", 32'(MispredictE_o), 32'd0);

    // asynchronous reset mid-operation, then two loads before E is valid
    load_pred(1'b1, 32'hD00, 6'b000000);
    set_e(7'd103, 1'b0, 32'hD08, 32'hD04);
    #1;
    check("midrst.before", 32'(MispredictE_o), 32'd1);
    reset_ni = 1'b0;
    check_e("midrst", 1'b0, 32'hD08, 1'b0, 1'b0, 1'b0, 6'b000000);
    reset_ni = 1'b1;
    set_f(1'b1, 32'hE00, '0);
    set_e(7'd51, 1'b0, 32'h0, 32'hE04);
    tick();
    check("midrst.load1", 32'(MispredictE_o), 32'd0);
    tick();
    check("midrst.load2", 32'(MispredictE_o), 32'd1);
    set_f(1'b0, 32'h0, '0);

`ifdef BRANCH_RESOLVE_STATS_EN
    // statistics: 3 branches, 1 mispredict, then asynchronous clear
    reset_ni = 1'b0;
    #1;
    check("stats.rst.br", BranchCountE_o,  32'd0);
    check("stats.rst.mp", MispredCountE_o, 32'd0);
    reset_ni = 1'b1;
    load_pred(1'b1, 32'h100, 6'b000000);
    set_e(7'd99, 1'b1, 32'h100, 32'h104);
    tick();
    load_pred(1'b0, 32'h0, 6'b000101);
    set_e(7'd99, 1'b1, 32'h200, 32'h1C);
    tick();
    load_pred(1'b1, 32'h800, 6'b010101);
    set_e(7'd111, 1'b0, 32'h800, 32'h10C);
    tick();
    set_e(7'd0, 1'b0, 32'h0, 32'h0);
    check("stats.br", BranchCountE_o,  32'd3);
    check("stats.mp", MispredCountE_o, 32'd1);
    reset_ni = 1'b0;
    #1;
    check("stats.clr.br", BranchCountE_o,  32'd0);
    check("stats.clr.mp", MispredCountE_o, 32'd0);
    reset_ni = 1'b1;
`endif

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
